// File: rtl/eq_pkg.sv
// Shared defaults and helpers for the N-band equalizer core.
package eq_pkg;
   localparam int DW    = 16;
   localparam int GW    = 16;
   localparam int GFRAC = 12;
   localparam logic [GW-1:0] UNITY_GAIN = GW'(1 << GFRAC);

   function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] value,
                                                    input int width);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (width - 1));
      if (value > hi) return hi;
      if (value < lo) return lo;
      return value;
   endfunction
endpackage

// File: rtl/eq_nband_core_if.sv
// Sample, gain-programming and status bundle of the equalizer core.
interface eq_nband_core_if #(
   parameter int NBANDS = 8,
   parameter int DW     = 16,
   parameter int GW     = 16
);
   localparam int AW = $clog2(NBANDS);

   logic [NBANDS-1:0][DW-1:0] band_in;
   logic                      in_valid;
   logic                      gain_we;
   logic [AW-1:0]             gain_addr;
   logic [GW-1:0]             gain_data;
   logic                      gain_commit;
   logic                      bypass;
   logic                      sat_clr;
   logic [DW-1:0]             y;
   logic                      out_valid;
   logic                      sat_flag;

   modport master (
      output band_in, in_valid, gain_we, gain_addr, gain_data, gain_commit, bypass, sat_clr,
      input  y, out_valid, sat_flag
   );

   modport slave (
      input  band_in, in_valid, gain_we, gain_addr, gain_data, gain_commit, bypass, sat_clr,
      output y, out_valid, sat_flag
   );
endinterface

// File: rtl/eq_gain_mul.sv
// One band's gain stage: signed multiply, round half-up, register.
module eq_gain_mul
   import eq_pkg::*;
#(
   parameter int DW    = eq_pkg::DW,
   parameter int GW    = eq_pkg::GW,
   parameter int GFRAC = eq_pkg::GFRAC
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [DW-1:0]                  band_i,
   input  logic [GW-1:0]                  gain_i,
   output logic signed [DW+GW-GFRAC-1:0]  prod_o
);
   localparam int PW = DW + GW - GFRAC;
   localparam int FW = DW + GW;
   localparam logic signed [FW-1:0] HALF = FW'(1) << (GFRAC - 1);

   logic signed [FW-1:0] full_w;
   logic signed [FW-1:0] rnd_w;
   logic signed [PW-1:0] prod_d;
   logic signed [PW-1:0] prod_q;

   always_comb begin
      full_w = FW'($signed(band_i)) * FW'($signed(gain_i));
      rnd_w  = full_w + HALF;
      prod_d = PW'(rnd_w >>> GFRAC);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) prod_q <= '0;
      else     prod_q <= prod_d;
   end

   assign prod_o = prod_q;
endmodule

// File: rtl/eq_nband_core.sv
// N-band equalizer: double-buffered gains, per-band gain stage, registered
// adder tree and saturating output with sticky saturation flag.
module eq_nband_core
   import eq_pkg::*;
#(
   parameter int NBANDS = 8,
   parameter int DW     = eq_pkg::DW,
   parameter int GW     = eq_pkg::GW,
   parameter int GFRAC  = eq_pkg::GFRAC
) (
   input  logic            clk,
   input  logic            rst,
   eq_nband_core_if.slave  bus
);
   localparam int LV = $clog2(NBANDS);
   localparam int PW = DW + GW - GFRAC;
   localparam int TW = PW + LV;
   localparam logic [GW-1:0] UNITY = GW'(64'd1 << GFRAC);

   if (NBANDS < 2 || (NBANDS & (NBANDS - 1)) != 0 || GFRAC >= GW) begin : g_bad_cfg
      $error("eq_nband_core: NBANDS must be a power of two >= 2 and GFRAC < GW");
   end

   logic [GW-1:0] shadow_q [NBANDS];
   logic [GW-1:0] shadow_d [NBANDS];
   logic [GW-1:0] active_q [NBANDS];
   logic [GW-1:0] active_d [NBANDS];

   // Commit copies shadow_d so a same-cycle write lands in the active set.
   always_comb begin
      shadow_d = shadow_q;
      if (bus.gain_we) shadow_d[bus.gain_addr] = bus.gain_data;
      active_d = bus.gain_commit ? shadow_d : active_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NBANDS; i++) begin
            shadow_q[i] <= UNITY;
            active_q[i] <= UNITY;
         end
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
      end
   end

   logic signed [PW-1:0] leaf [NBANDS];

   for (genvar k = 0; k < NBANDS; k++) begin : g_band
      logic [GW-1:0] gain_sel;
      assign gain_sel = bus.bypass ? UNITY : active_q[k];
      eq_gain_mul #(.DW(DW), .GW(GW), .GFRAC(GFRAC)) u_mul (
         .clk    (clk),
         .rst    (rst),
         .band_i (bus.band_in[k]),
         .gain_i (gain_sel),
         .prod_o (leaf[k])
      );
   end

   // Heap-ordered tree: node i sums nodes 2i+1 and 2i+2; leaves sit at NBANDS-1.
   logic signed [TW-1:0] node_q [NBANDS-1];
   logic signed [TW-1:0] node_d [NBANDS-1];
   logic signed [TW-1:0] tree_n [2*NBANDS-1];

   always_comb begin
      for (int i = 0; i < NBANDS - 1; i++) tree_n[i] = node_q[i];
      for (int k = 0; k < NBANDS; k++) tree_n[NBANDS-1+k] = TW'(leaf[k]);
   end

   always_comb begin
      for (int i = 0; i < NBANDS - 1; i++) node_d[i] = tree_n[2*i+1] + tree_n[2*i+2];
   end

   logic [LV:0]          vld_q, vld_d;
   logic signed [63:0]   root_w, clamp_w;
   logic                 sat_w;
   logic [DW-1:0]        y_q, y_d;
   logic                 out_valid_q, out_valid_d;
   logic                 sat_flag_q, sat_flag_d;

   always_comb begin
      vld_d       = {vld_q[LV-1:0], bus.in_valid};
      root_w      = 64'(node_q[0]);
      clamp_w     = sat_clamp(root_w, DW);
      sat_w       = (clamp_w != root_w);
      y_d         = DW'(clamp_w);
      out_valid_d = vld_q[LV];
      sat_flag_d  = sat_flag_q;
      if (sat_w && vld_q[LV]) sat_flag_d = 1'b1;
      else if (bus.sat_clr)   sat_flag_d = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NBANDS - 1; i++) node_q[i] <= '0;
         vld_q       <= '0;
         y_q         <= '0;
         out_valid_q <= 1'b0;
         sat_flag_q  <= 1'b0;
      end else begin
         node_q      <= node_d;
         vld_q       <= vld_d;
         y_q         <= y_d;
         out_valid_q <= out_valid_d;
         sat_flag_q  <= sat_flag_d;
      end
   end

   assign bus.y         = y_q;
   assign bus.out_valid = out_valid_q;
   assign bus.sat_flag  = sat_flag_q;
endmodule

// File: tb/tb_eq_nband_core.sv
// Scoreboard bench for eq_nband_core (NBANDS=8, DW=16, GW=16, GFRAC=12).
module tb_eq_nband_core;
   localparam int NB = 8;
   typedef int band_arr_t [NB];

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   eq_nband_core_if #(.NBANDS(NB), .DW(16), .GW(16)) bus ();

   eq_nband_core #(.NBANDS(NB), .DW(16), .GW(16), .GFRAC(12)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int        checks = 0;
   int        errors = 0;
   int        exp_q[$];
   int        tb_shadow [NB];
   int        tb_active [NB];
   int        ov_run = 0;
   int        ov_max = 0;
   int        mon_e;
   logic [15:0] mon_ey;
   band_arr_t zb;

   initial begin
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   always @(negedge clk) begin
      if (rst) begin
         ov_run = 0;
      end else if (bus.out_valid) begin
         ov_run++;
         if (ov_run > ov_max) ov_max = ov_run;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out: y=%0d but no sample expected", $signed(bus.y));
         end else begin
            mon_e  = exp_q.pop_front();
            mon_ey = mon_e[15:0];
            if (bus.y !== mon_ey) begin
               errors++;
               $display("FAIL y_value: got %0d expected %0d", $signed(bus.y), $signed(mon_ey));
            end
         end
      end else begin
         ov_run = 0;
      end
   end

   function automatic int model_y(input band_arr_t b, input bit byp);
      longint acc = 0;
      longint g;
      for (int k = 0; k < NB; k++) begin
         g   = byp ? 64'sd4096 : longint'(tb_active[k]);
         acc += (longint'(b[k]) * g + 64'sd2048) >>> 12;
      end
      if (acc > 32767)  acc = 32767;
      if (acc < -32768) acc = -32768;
      return int'(acc);
   endfunction

   function automatic band_arr_t fill(input int v);
      band_arr_t b;
      for (int k = 0; k < NB; k++) b[k] = v;
      return b;
   endfunction

   task automatic drive_cycle(input bit vld, input band_arr_t b, input bit byp, input bit we,
                              input int addr, input int data, input bit cm, input bit clr,
                              input bit use_ex, input int ex);
      for (int k = 0; k < NB; k++) bus.band_in[k] = 16'(b[k]);
      bus.in_valid    = vld;
      bus.bypass      = byp;
      bus.gain_we     = we;
      bus.gain_addr   = 3'(addr);
      bus.gain_data   = 16'(data);
      bus.gain_commit = cm;
      bus.sat_clr     = clr;
      if (vld) exp_q.push_back(use_ex ? ex : model_y(b, byp));
      if (we) tb_shadow[addr] = data;
      if (cm) tb_active = tb_shadow;
      @(negedge clk);
      bus.in_valid    = 1'b0;
      bus.bypass      = 1'b0;
      bus.gain_we     = 1'b0;
      bus.gain_commit = 1'b0;
      bus.sat_clr     = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) drive_cycle(0, zb, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic send_ex(input band_arr_t b, input int ex);
      drive_cycle(1, b, 0, 0, 0, 0, 0, 0, 1, ex);
   endtask

   task automatic write_gain(input int addr, input int data, input bit cm);
      drive_cycle(0, zb, 0, 1, addr, data, cm, 0, 0, 0);
   endtask

   task automatic commit_gains();
      drive_cycle(0, zb, 0, 0, 0, 0, 1, 0, 0, 0);
   endtask

   task automatic pulse_clr();
      drive_cycle(0, zb, 0, 0, 0, 0, 0, 1, 0, 0);
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s_drain: %0d outputs missing after 20 cycles", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      bus.band_in = '0; bus.in_valid = 0; bus.gain_we = 0; bus.gain_addr = '0;
      bus.gain_data = '0; bus.gain_commit = 0; bus.bypass = 0; bus.sat_clr = 0;
      for (int k = 0; k < NB; k++) begin
         tb_shadow[k] = 4096;
         tb_active[k] = 4096;
         zb[k] = 0;
      end
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (bus.y !== 16'd0) begin errors++; $display("FAIL reset_y: got %0d expected 0", bus.y); end
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
      checks++;
      if (bus.sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat_flag: got %b expected 0", bus.sat_flag); end
      rst = 1'b0;
      idle(2);
   endtask

   task automatic test_unity();
      int lat;
      send_ex(fill(100), 800);
      lat = 1;
      while (!bus.out_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (lat != 5) begin errors++; $display("FAIL unity_latency: got %0d expected 5", lat); end
      checks++;
      if (bus.sat_flag !== 1'b0) begin errors++; $display("FAIL unity_sat_flag: got %b expected 0", bus.sat_flag); end
      drain("unity");
   endtask

   task automatic test_gain_round();
      band_arr_t b = zb;
      write_gain(3, 'h2000, 0);
      commit_gains();
      b[3] = 1000;
      send_ex(b, 2000);
      drain("gain_x2");
      write_gain(3, 'h0800, 0);
      commit_gains();
      b[3] = 3;
      send_ex(b, 2);
      drain("gain_round");
   endtask

   task automatic test_uncommitted();
      band_arr_t b = zb;
      write_gain(0, 0, 0);
      b[0] = 500;
      send_ex(b, 500);
      drain("uncommitted");
      write_gain(0, 4096, 0);
      write_gain(0, 0, 1);
      send_ex(b, 0);
      drain("same_cycle_commit");
   endtask

   task automatic test_saturation();
      write_gain(0, 4096, 0);
      write_gain(3, 4096, 1);
      send_ex(fill(32767), 32767);
      drain("sat_pos");
      checks++;
      if (bus.sat_flag !== 1'b1) begin errors++; $display("FAIL sat_pos_flag: got %b expected 1", bus.sat_flag); end
      pulse_clr();
      checks++;
      if (bus.sat_flag !== 1'b0) begin errors++; $display("FAIL sat_clr_alone: got %b expected 0", bus.sat_flag); end
      send_ex(fill(-32768), -32768);
      drain("sat_neg");
      checks++;
      if (bus.sat_flag !== 1'b1) begin errors++; $display("FAIL sat_neg_flag: got %b expected 1", bus.sat_flag); end
      pulse_clr();
      send_ex(fill(-32768), -32768);
      idle(3);
      pulse_clr();
      checks++;
      if (bus.sat_flag !== 1'b1) begin errors++; $display("FAIL sat_set_wins: got %b expected 1", bus.sat_flag); end
      drain("sat_set_wins");
      pulse_clr();
      checks++;
      if (bus.sat_flag !== 1'b0) begin errors++; $display("FAIL sat_clr_final: got %b expected 0", bus.sat_flag); end
   endtask

   task automatic test_back_to_back();
      band_arr_t b;
      for (int k = 0; k < NB; k++) write_gain(k, int'($urandom_range(1024, 8192)), k == NB - 1);
      ov_max = 0;
      for (int n = 0; n < 12; n++) begin
         for (int k = 0; k < NB; k++) b[k] = int'($urandom_range(0, 8000)) - 4000;
         if (n < NB)
            drive_cycle(1, b, 0, 1, n, int'($urandom_range(0, 12288)) - 4096, n == NB - 1, 0, 0, 0);
         else
            drive_cycle(1, b, 0, 0, 0, 0, 0, 0, 0, 0);
      end
      drain("stream");
      checks++;
      if (ov_max != 12) begin errors++; $display("FAIL stream_no_gaps: longest out_valid run %0d expected 12", ov_max); end
   endtask

   task automatic test_bypass();
      band_arr_t b;
      for (int k = 0; k < NB; k++) b[k] = (k + 1) * 100;
      drive_cycle(1, b, 1, 0, 0, 0, 0, 0, 1, 3600);
      drive_cycle(1, b, 0, 0, 0, 0, 0, 0, 0, 0);
      drain("bypass");
   endtask

   task automatic test_reset_mid();
      band_arr_t b;
      int lat;
      for (int n = 0; n < 7; n++) begin
         for (int k = 0; k < NB; k++) b[k] = int'($urandom_range(0, 2000)) - 1000;
         drive_cycle(1, b, 0, 0, 0, 0, 0, 0, 0, 0);
      end
      checks++;
      if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid: got %b expected 1", bus.out_valid); end
      rst = 1'b1;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_drop: got %b expected 0", bus.out_valid); end
      exp_q.delete();
      for (int k = 0; k < NB; k++) begin
         tb_shadow[k] = 4096;
         tb_active[k] = 4096;
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      idle(10);
      for (int k = 0; k < NB; k++) b[k] = (k + 1) * 10;
      send_ex(b, 360);
      lat = 1;
      while (!bus.out_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (lat != 5) begin errors++; $display("FAIL midrst_latency: got %0d expected 5", lat); end
      drain("midrst");
   endtask

   initial begin
      test_reset();
      test_unity();
      test_gain_round();
      test_uncommitted();
      test_saturation();
      test_back_to_back();
      test_bypass();
      test_reset_mid();
      idle(3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
